// File: rtl/rs_decode_pkg.sv
// Shared definitions for the RS decode-side stream reorder block.
package rs_decode_pkg;

  localparam int unsigned RS_K     = 32;
  localparam int unsigned RS_N     = 34;
  localparam int unsigned PARITY_W = 8 * (RS_N - RS_K);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA_IN = 2'd1,
    ST_PAR_IN  = 2'd2,
    ST_EMIT    = 2'd3
  } dec_state_e;

  // Per-line framing flags carried alongside each codeword line
  typedef struct packed {
    logic block_last;
    logic last;
  } line_tag_t;

  // Data lines needed to carry RS_K message bytes at a given line width
  function automatic int unsigned num_lines(input int unsigned data_w);
    return (RS_K + (data_w / 8) - 1) / (data_w / 8);
  endfunction

endpackage

// File: rtl/rs_decode_stream_reorder_line_buf.sv
// Data line store with a synchronous read stage feeding a 1-entry output register.
module rs_decode_stream_reorder_line_buf
  import rs_decode_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  input  logic [PARITY_W-1:0] rd_parity_i,
  input  line_tag_t           rd_tag_i,
  output logic                rd_rdy_c_o,
  output logic                out_val_o,
  output logic [DATA_W-1:0]   out_line_o,
  output logic [PARITY_W-1:0] out_parity_o,
  output line_tag_t           out_tag_o,
  input  logic                out_rdy_i
);

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   rd_line_q;
  logic                rd_val_q;
  logic [PARITY_W-1:0] rd_par_q;
  line_tag_t           rd_tag_q;
  logic                out_val_q;
  logic [DATA_W-1:0]   out_line_q;
  logic [PARITY_W-1:0] out_par_q;
  line_tag_t           out_tag_q;
  logic                adv_c;

  // Whole pipe shifts only when the output slot is empty or being taken
  assign adv_c      = !out_val_q || out_rdy_i;
  assign rd_rdy_c_o = adv_c;

  // Memory write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (adv_c && rd_en_i) begin
      rd_line_q <= mem_q[rd_addr_i];
    end
  end

  // Read-stage flags and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_val_q   <= 1'b0;
      rd_par_q   <= '0;
      rd_tag_q   <= '0;
      out_val_q  <= 1'b0;
      out_line_q <= '0;
      out_par_q  <= '0;
      out_tag_q  <= '0;
    end else if (flush_i) begin
      rd_val_q  <= 1'b0;
      out_val_q <= 1'b0;
    end else if (adv_c) begin
      rd_val_q <= rd_en_i;
      if (rd_en_i) begin
        rd_par_q <= rd_parity_i;
        rd_tag_q <= rd_tag_i;
      end
      out_val_q <= rd_val_q;
      if (rd_val_q) begin
        out_line_q <= rd_line_q;
        out_par_q  <= rd_par_q;
        out_tag_q  <= rd_tag_q;
      end
    end
  end

  assign out_val_o    = out_val_q;
  assign out_line_o   = out_line_q;
  assign out_parity_o = out_par_q;
  assign out_tag_o    = out_tag_q;

endmodule

// File: rtl/rs_decode_stream_reorder.sv
// Reorders a transmit-format RS stream (all data lines, then packed parity
// lines) into per-block codewords with parity attached to each block's last line.
// Optional framing check: define RS_DECODE_STREAM_LAST_CHECK_EN.
module rs_decode_stream_reorder
  import rs_decode_pkg::*;
#(
  parameter int unsigned NUM_REQ_BLOCKS   = 8,
  parameter int unsigned NUM_REQ_BLOCKS_W = $clog2(NUM_REQ_BLOCKS) + 1,
  parameter int unsigned DATA_W           = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        src_decoder_req_val,
  input  logic [NUM_REQ_BLOCKS_W-1:0] src_decoder_req_num_blocks,
  output logic                        decoder_src_req_rdy,
  input  logic                        src_decoder_req_data_val,
  input  logic [DATA_W-1:0]           src_decoder_req_data,
  input  logic                        src_decoder_req_data_last,
  output logic                        decoder_src_req_data_rdy,
  output logic                        decoder_dst_line_val,
  output logic [DATA_W-1:0]           decoder_dst_line,
  output logic [PARITY_W-1:0]         decoder_dst_parity,
  output logic                        decoder_dst_block_last,
  output logic                        decoder_dst_last,
  input  logic                        dst_decoder_line_rdy,
  output logic                        decoder_len_err
);

  localparam int unsigned NUM_LINES    = num_lines(DATA_W);
  localparam int unsigned PAR_PER_LINE = DATA_W / PARITY_W;
  localparam int unsigned DEPTH        = NUM_REQ_BLOCKS * NUM_LINES;
  localparam int unsigned ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LINE_W       = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int unsigned WIDX_W       = (PAR_PER_LINE > 1) ? $clog2(PAR_PER_LINE) : 1;
  localparam int unsigned BLK_W        = NUM_REQ_BLOCKS_W;

  dec_state_e                              state_q, state_d;
  logic [BLK_W-1:0]                        num_q, num_d;
  logic [BLK_W-1:0]                        blk_q, blk_d;
  logic [LINE_W-1:0]                       line_q, line_d;
  logic [WIDX_W-1:0]                       widx_q, widx_d;
  logic [PAR_PER_LINE-1:0][PARITY_W-1:0]   par_q, par_d;
  logic                                    done_q, done_d;
  logic                                    len_err_q, len_err_d;
  logic                                    req_rdy_q, req_rdy_d;
  logic                                    data_rdy_q, data_rdy_d;

  logic              req_hs_c, data_hs_c, dst_last_hs_c;
  logic              line_end_c, blk_end_c, par_final_c;
  logic [BLK_W-1:0]  rem_c;
  logic [ADDR_W-1:0] addr_c;
  logic              wr_en_c, rd_en_c, flush_c, rd_rdy_c;
  logic [PARITY_W-1:0] rd_par_c;
  line_tag_t         rd_tag_c, out_tag_c;
  logic              last_in_c, check_en_c;

`ifdef RS_DECODE_STREAM_LAST_CHECK_EN
  assign last_in_c  = src_decoder_req_data_last;
  assign check_en_c = 1'b1;
`else
  logic unused_last_c;
  assign unused_last_c = src_decoder_req_data_last;
  assign last_in_c     = 1'b0;
  assign check_en_c    = 1'b0;
`endif

  assign req_hs_c      = src_decoder_req_val && req_rdy_q;
  assign data_hs_c     = src_decoder_req_data_val && data_rdy_q;
  assign dst_last_hs_c = decoder_dst_line_val && dst_decoder_line_rdy && decoder_dst_last;

  assign line_end_c  = (line_q == LINE_W'(NUM_LINES - 1));
  assign blk_end_c   = (blk_q == num_q - BLK_W'(1));
  assign rem_c       = num_q - blk_q;
  assign par_final_c = (rem_c <= BLK_W'(PAR_PER_LINE));
  assign addr_c      = ADDR_W'(blk_q) * ADDR_W'(NUM_LINES) + ADDR_W'(line_q);

  // Sideband travelling with each issued read
  always_comb begin
    rd_tag_c.block_last = line_end_c;
    rd_tag_c.last       = line_end_c && blk_end_c;
    rd_par_c            = line_end_c ? par_q[widx_q] : '0;
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      blk_q      <= '0;
      line_q     <= '0;
      widx_q     <= '0;
      par_q      <= '0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
      req_rdy_q  <= 1'b0;
      data_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      blk_q      <= blk_d;
      line_q     <= line_d;
      widx_q     <= widx_d;
      par_q      <= par_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
      req_rdy_q  <= req_rdy_d;
      data_rdy_q <= data_rdy_d;
    end
  end

  // Next-state: ingest counting, parity line capture and emit read sequencing
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    blk_d     = blk_q;
    line_d    = line_q;
    widx_d    = widx_q;
    par_d     = par_q;
    done_d    = done_q;
    len_err_d = len_err_q;
    wr_en_c   = 1'b0;
    rd_en_c   = 1'b0;
    flush_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_hs_c) begin
          num_d  = src_decoder_req_num_blocks;
          blk_d  = '0;
          line_d = '0;
          widx_d = '0;
          done_d = 1'b0;
          if (src_decoder_req_num_blocks != '0) begin
            state_d = ST_DATA_IN;
          end
        end
      end

      ST_DATA_IN: begin
        if (data_hs_c) begin
          if (last_in_c) begin
            len_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            wr_en_c = 1'b1;
            if (line_end_c) begin
              line_d = '0;
              if (blk_end_c) begin
                blk_d   = '0;
                state_d = ST_PAR_IN;
              end else begin
                blk_d = blk_q + BLK_W'(1);
              end
            end else begin
              line_d = line_q + LINE_W'(1);
            end
          end
        end
      end

      ST_PAR_IN: begin
        if (data_hs_c) begin
          if (last_in_c && !par_final_c) begin
            len_err_d = 1'b1;
            flush_c   = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            par_d   = src_decoder_req_data;
            widx_d  = '0;
            state_d = ST_EMIT;
            if (check_en_c && par_final_c && !last_in_c) begin
              len_err_d = 1'b1;
            end
          end
        end
      end

      ST_EMIT: begin
        if (!done_q) begin
          if (rd_rdy_c) begin
            rd_en_c = 1'b1;
            if (line_end_c) begin
              line_d = '0;
              if (blk_end_c) begin
                done_d = 1'b1;
              end else begin
                blk_d = blk_q + BLK_W'(1);
                if (widx_q == WIDX_W'(PAR_PER_LINE - 1)) begin
                  state_d = ST_PAR_IN;
                end else begin
                  widx_d = widx_q + WIDX_W'(1);
                end
              end
            end else begin
              line_d = line_q + LINE_W'(1);
            end
          end
        end else if (dst_last_hs_c) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    req_rdy_d  = (state_d == ST_IDLE);
    data_rdy_d = (state_d == ST_DATA_IN) || (state_d == ST_PAR_IN);
  end

  rs_decode_stream_reorder_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_c),
    .wr_en_i      (wr_en_c),
    .wr_addr_i    (addr_c),
    .wr_data_i    (src_decoder_req_data),
    .rd_en_i      (rd_en_c),
    .rd_addr_i    (addr_c),
    .rd_parity_i  (rd_par_c),
    .rd_tag_i     (rd_tag_c),
    .rd_rdy_c_o   (rd_rdy_c),
    .out_val_o    (decoder_dst_line_val),
    .out_line_o   (decoder_dst_line),
    .out_parity_o (decoder_dst_parity),
    .out_tag_o    (out_tag_c),
    .out_rdy_i    (dst_decoder_line_rdy)
  );

  assign decoder_dst_block_last   = out_tag_c.block_last;
  assign decoder_dst_last         = out_tag_c.last;
  assign decoder_src_req_rdy      = req_rdy_q;
  assign decoder_src_req_data_rdy = data_rdy_q;
  assign decoder_len_err          = len_err_q;

endmodule

// File: tb/tb_rs_decode_stream_reorder.sv
// Randomized bench for rs_decode_stream_reorder with a queue-based codeword model.
module tb_rs_decode_stream_reorder;
  import rs_decode_pkg::*;

  localparam int unsigned NRB   = 8;
  localparam int unsigned NRB_W = 4;
  localparam int unsigned DW    = 64;
  localparam int unsigned BYTES = DW / 8;
  localparam int unsigned NL    = (RS_K + BYTES - 1) / BYTES;
  localparam int unsigned PPL   = DW / PARITY_W;
  localparam int          TMO   = 2000;

  typedef struct {
    logic [DW-1:0]       line;
    logic [PARITY_W-1:0] par;
    bit                  bl;
    bit                  last;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req_val;
  logic [NRB_W-1:0]    req_nb;
  logic                req_rdy;
  logic                data_val;
  logic [DW-1:0]       data;
  logic                data_last;
  logic                data_rdy;
  logic                line_val;
  logic [DW-1:0]       line;
  logic [PARITY_W-1:0] par;
  logic                blast;
  logic                last;
  logic                dst_rdy;
  logic                len_err;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rs_decode_stream_reorder #(
    .NUM_REQ_BLOCKS   (NRB),
    .NUM_REQ_BLOCKS_W (NRB_W),
    .DATA_W           (DW)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .src_decoder_req_val        (req_val),
    .src_decoder_req_num_blocks (req_nb),
    .decoder_src_req_rdy        (req_rdy),
    .src_decoder_req_data_val   (data_val),
    .src_decoder_req_data       (data),
    .src_decoder_req_data_last  (data_last),
    .decoder_src_req_data_rdy   (data_rdy),
    .decoder_dst_line_val       (line_val),
    .decoder_dst_line           (line),
    .decoder_dst_parity         (par),
    .decoder_dst_block_last     (blast),
    .decoder_dst_last           (last),
    .dst_decoder_line_rdy       (dst_rdy),
    .decoder_len_err            (len_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  // Called at a negedge; returns at the negedge after the header handshake
  task automatic send_hdr(input int n);
    int w = 0;
    req_val = 1'b1;
    req_nb  = NRB_W'(n);
    while (!req_rdy && w < TMO) begin
      @(negedge clk);
      w++;
    end
    if (w >= TMO) timeout_fail("hdr_wait");
    chk("hs_exclusive", data_rdy, 0);
    @(negedge clk);
    req_val = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the line handshake
  task automatic drive_line(input logic [DW-1:0] d, input bit l, output longint hs_cyc);
    int w = 0;
    data_val  = 1'b1;
    data      = d;
    data_last = l;
    while (!data_rdy && w < TMO) begin
      @(negedge clk);
      w++;
    end
    if (w >= TMO) timeout_fail("line_wait");
    hs_cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic run_req(input int n, input int bp, input int last_at, input bit abcd);
    logic [DW-1:0] stim[$];
    bit            lf[$];
    logic [DW-1:0] pl[$];
    exp_t          expq[$];
    int            npar;
    longint        par_hs;
    longint        first_val;
    npar      = (n + PPL - 1) / PPL;
    par_hs    = -1;
    first_val = -1;
    for (int i = 0; i < n * NL; i++) begin
      stim.push_back({$urandom(), $urandom()});
      lf.push_back(i == last_at);
    end
    for (int j = 0; j < npar; j++) begin
      logic [DW-1:0] w;
      w = {$urandom(), $urandom()};
      if (abcd && j == 0) w[PARITY_W-1:0] = 16'hABCD;
      pl.push_back(w);
      stim.push_back(w);
      lf.push_back(j == npar - 1);
    end
    for (int b = 0; b < n; b++) begin
      for (int l = 0; l < NL; l++) begin
        exp_t e;
        e.line = stim[b * NL + l];
        e.bl   = (l == NL - 1);
        e.par  = PARITY_W'(pl[b / PPL] >> (PARITY_W * (b % PPL)));
        e.last = e.bl && (b == n - 1);
        expq.push_back(e);
      end
    end

    send_hdr(n);
    fork
      begin
        for (int i = 0; i < stim.size(); i++) begin
          longint h;
          drive_line(stim[i], lf[i], h);
          if (i == n * NL) par_hs = h;
        end
        data_val  = 1'b0;
        data_last = 1'b0;
      end
      begin
        int got = 0;
        int w   = 0;
        while (got < expq.size() && w < TMO) begin
          dst_rdy = ($urandom_range(99) >= bp);
          if (line_val) begin
            if (first_val < 0) first_val = cyc;
            if (dst_rdy) begin
              chk("line", line, expq[got].line);
              chk("block_last", blast, 64'(expq[got].bl));
              chk("last", last, 64'(expq[got].last));
              if (expq[got].bl) chk("parity", par, expq[got].par);
              got++;
            end
          end
          @(negedge clk);
          w++;
        end
        if (got < expq.size()) timeout_fail("emit_wait");
      end
    join
    chk("emit_latency", 64'(first_val - par_hs), 2);
    chk("post_req_rdy", req_rdy, 1);
    chk("post_line_val", line_val, 0);
    chk("post_data_rdy", data_rdy, 0);
  endtask

  initial begin
    logic [DW-1:0] rv[$];
    longint        h;
    int            seen;

    rst_n     = 1'b0;
    req_val   = 1'b0;
    req_nb    = '0;
    data_val  = 1'b0;
    data      = '0;
    data_last = 1'b0;
    dst_rdy   = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_data_rdy", data_rdy, 0);
    chk("rst_line_val", line_val, 0);
    chk("rst_line", line, 0);
    chk("rst_parity", par, 0);
    chk("rst_block_last", blast, 0);
    chk("rst_last", last, 0);
    chk("rst_len_err", len_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_rdy", req_rdy, 1);

    // Single block, parity word 0 forced
    run_req(1, 0, -1, 1'b1);
    // Two parity lines, unused words dropped
    run_req(PPL + 1, 0, -1, 1'b0);
    // Full request under 50% backpressure
    run_req(NRB, 50, -1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_req($urandom_range(NRB, 1), 50, -1, 1'b0);
    end

    // Zero-block request: accepted with no output
    send_hdr(0);
    chk("zero_req_rdy", req_rdy, 1);
    chk("zero_data_rdy", data_rdy, 0);
    seen = 0;
    repeat (6) begin
      if (line_val) seen++;
      @(negedge clk);
    end
    chk("zero_no_output", seen, 0);

    // Reset while a codeword is stalled at the output
    send_hdr(4);
    dst_rdy = 1'b0;
    for (int i = 0; i < 4 * NL + 1; i++) begin
      rv.push_back({$urandom(), $urandom()});
      drive_line(rv[i], i == 4 * NL, h);
    end
    data_val  = 1'b0;
    data_last = 1'b0;
    repeat (4) @(negedge clk);
    chk("stall_val", line_val, 1);
    chk("stall_line", line, rv[0]);
    @(negedge clk);
    chk("stall_hold", line, rv[0]);
    rst_n = 1'b0;
    #1;
    chk("abort_line_val", line_val, 0);
    chk("abort_req_rdy", req_rdy, 0);
    chk("abort_data_rdy", data_rdy, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    dst_rdy = 1'b1;
    @(negedge clk);
    run_req(2, 30, -1, 1'b0);

    // Early last on the 3rd data line
`ifdef RS_DECODE_STREAM_LAST_CHECK_EN
    send_hdr(2);
    for (int i = 0; i < 3; i++) begin
      drive_line({$urandom(), $urandom()}, i == 2, h);
    end
    data_val  = 1'b0;
    data_last = 1'b0;
    seen = 0;
    repeat (4) begin
      if (line_val) seen++;
      @(negedge clk);
    end
    chk("early_len_err", len_err, 1);
    chk("early_req_rdy", req_rdy, 1);
    chk("early_data_rdy", data_rdy, 0);
    chk("early_no_output", seen, 0);
`else
    run_req(2, 0, 2, 1'b0);
    chk("ignored_len_err", len_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
